fuzzy_rule_sequencer: RTL and testbench

//  Time-multiplexed fuzzy rule engine: captures the six input memberships (T and dT, 3 sets each) and

---
 rtl/fuzzy_pkg.sv | 41 ++++
 rtl/fuzzy_rule_mac.sv | 63 ++++++
 rtl/fuzzy_rule_sequencer.sv | 166 ++++++++++++++++
 tb/tb_fuzzy_rule_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_pkg.sv
// rtl/fuzzy_pkg.sv - shared types and constants for the fuzzy rule sequencer
package fuzzy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  // Fuzzy set index within one input variable
  localparam logic [1:0] NEG  = 2'd0;
  localparam logic [1:0] ZERO = 2'd1;
  localparam logic [1:0] POS  = 2'd2;

  localparam int NRULES   = 9;
  localparam int MU_W_DEF = 16;
  localparam int Z_W_DEF  = 16;

  // Temperature set index of rule k = 3*i+j
  function automatic logic [1:0] rule_row(input logic [3:0] k);
    logic [1:0] r;
    case (k)
      4'd0, 4'd1, 4'd2: r = NEG;
      4'd3, 4'd4, 4'd5: r = ZERO;
      default:          r = POS;
    endcase
    return r;
  endfunction

  // dT set index of rule k = 3*i+j
  function automatic logic [1:0] rule_col(input logic [3:0] k);
    logic [1:0] c;
    case (k)
      4'd0, 4'd3, 4'd6: c = NEG;
      4'd1, 4'd4, 4'd7: c = ZERO;
      default:          c = POS;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fuzzy_rule_mac.sv
// rtl/fuzzy_rule_mac.sv - shared min/multiply unit with weight and weighted-sum accumulators
module fuzzy_rule_mac #(
  parameter int MU_W  = 16,
  parameter int Z_W   = 16,
  parameter int SW_W  = MU_W + 4,
  parameter int SWZ_W = MU_W + Z_W + 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    last_i,
  input  logic [MU_W-1:0]         mu_a_i,
  input  logic [MU_W-1:0]         mu_b_i,
  input  logic signed [Z_W-1:0]   z_i,
  output logic [SW_W-1:0]         sum_w_o,
  output logic signed [SWZ_W-1:0] sum_wz_o
);

  localparam int PROD_W = MU_W + Z_W + 1;

  logic [MU_W-1:0]          w;
  logic signed [PROD_W-1:0] prod;
  logic [SW_W-1:0]          term_w;
  logic signed [SWZ_W-1:0]  term_wz;

  logic [SW_W-1:0]          acc_w_q;
  logic signed [SWZ_W-1:0]  acc_wz_q;
  logic [SW_W-1:0]          sum_w_q;
  logic signed [SWZ_W-1:0]  sum_wz_q;

  // Rule weight and its contribution; w gets a zero sign bit so it multiplies as a positive value
  always_comb begin
    w       = (mu_a_i < mu_b_i) ? mu_a_i : mu_b_i;
    prod    = $signed({1'b0, w}) * z_i;
    term_w  = {{(SW_W-MU_W){1'b0}}, w};
    term_wz = {{(SWZ_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  // Running accumulators; the visible sums load only on the final rule so they hold between runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_w_q  <= '0;
      acc_wz_q <= '0;
      sum_w_q  <= '0;
      sum_wz_q <= '0;
    end else if (clr_i) begin
      acc_w_q  <= '0;
      acc_wz_q <= '0;
    end else if (en_i) begin
      acc_w_q  <= acc_w_q + term_w;
      acc_wz_q <= acc_wz_q + term_wz;
      if (last_i) begin
        sum_w_q  <= acc_w_q + term_w;
        sum_wz_q <= acc_wz_q + term_wz;
      end
    end
  end

  assign sum_w_o  = sum_w_q;
  assign sum_wz_o = sum_wz_q;

endmodule

// File: rtl/fuzzy_rule_sequencer.sv
// rtl/fuzzy_rule_sequencer.sv - 3x3 fuzzy rule engine, one rule per cycle; FUZZY_RULE_TRACE_EN adds trace outputs
module fuzzy_rule_sequencer
  import fuzzy_pkg::*;
#(
  parameter int MU_W = MU_W_DEF,
  parameter int Z_W  = Z_W_DEF,
  localparam int SW_W  = MU_W + 4,
  localparam int SWZ_W = MU_W + Z_W + 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MU_W-1:0]         muT_neg,
  input  logic [MU_W-1:0]         muT_zero,
  input  logic [MU_W-1:0]         muT_pos,
  input  logic [MU_W-1:0]         muD_neg,
  input  logic [MU_W-1:0]         muD_zero,
  input  logic [MU_W-1:0]         muD_pos,
  input  logic                    cfg_we,
  input  logic [3:0]              cfg_addr,
  input  logic signed [Z_W-1:0]   cfg_data,
  output logic                    cfg_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SW_W-1:0]         sum_w,
  output logic signed [SWZ_W-1:0] sum_wz
`ifdef FUZZY_RULE_TRACE_EN
  ,
  output logic                    trc_valid,
  output logic [3:0]              trc_idx,
  output logic [MU_W-1:0]         trc_w
`endif
);

  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;

  logic [MU_W-1:0] mu_t_q [3];
  logic [MU_W-1:0] mu_d_q [3];
  logic signed [Z_W-1:0] z_q [NRULES];

  logic capture, mac_clr, mac_en, mac_last;
  logic [MU_W-1:0] mu_a, mu_b;

  // Sequencer state and rule index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: capture in IDLE, walk the 9 rules, wait for the sums to be taken
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    capture  = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    mac_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          mac_clr = 1'b1;
          idx_d   = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        mac_en = 1'b1;
        if (idx_q == 4'(NRULES - 1)) begin
          mac_last = 1'b1;
          idx_d    = '0;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign cfg_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Input latch so membership changes during a run do not disturb it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mu_t_q[k] <= '0;
        mu_d_q[k] <= '0;
      end
    end else if (capture) begin
      mu_t_q[0] <= muT_neg;
      mu_t_q[1] <= muT_zero;
      mu_t_q[2] <= muT_pos;
      mu_d_q[0] <= muD_neg;
      mu_d_q[1] <= muD_zero;
      mu_d_q[2] <= muD_pos;
    end
  end

  // Consequent table; writable only while idle and only for real rule indices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NRULES; k++) z_q[k] <= '0;
    end else if (cfg_we && cfg_ready && (cfg_addr < 4'(NRULES))) begin
      z_q[cfg_addr] <= cfg_data;
    end
  end

  // Antecedent operands of the current rule
  always_comb begin
    mu_a = mu_t_q[2];
    mu_b = mu_d_q[2];
    case (rule_row(idx_q))
      NEG:     mu_a = mu_t_q[0];
      ZERO:    mu_a = mu_t_q[1];
      POS:     mu_a = mu_t_q[2];
      default: mu_a = mu_t_q[2];
    endcase
    case (rule_col(idx_q))
      NEG:     mu_b = mu_d_q[0];
      ZERO:    mu_b = mu_d_q[1];
      POS:     mu_b = mu_d_q[2];
      default: mu_b = mu_d_q[2];
    endcase
  end

  fuzzy_rule_mac #(
    .MU_W  (MU_W),
    .Z_W   (Z_W),
    .SW_W  (SW_W),
    .SWZ_W (SWZ_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (mac_clr),
    .en_i     (mac_en),
    .last_i   (mac_last),
    .mu_a_i   (mu_a),
    .mu_b_i   (mu_b),
    .z_i      (z_q[idx_q]),
    .sum_w_o  (sum_w),
    .sum_wz_o (sum_wz)
  );

`ifdef FUZZY_RULE_TRACE_EN
  // Per-rule trace of the weight being accumulated this cycle
  always_comb begin
    trc_valid = (state_q == EVAL);
    trc_idx   = idx_q;
    trc_w     = (mu_a < mu_b) ? mu_a : mu_b;
  end
`endif

endmodule

// File: tb/tb_fuzzy_rule_sequencer.sv
// tb/tb_fuzzy_rule_sequencer.sv - self-checking bench for fuzzy_rule_sequencer
module tb_fuzzy_rule_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] muT_neg = '0, muT_zero = '0, muT_pos = '0;
  logic [15:0] muD_neg = '0, muD_zero = '0, muD_pos = '0;
  logic cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic signed [15:0] cfg_data = '0;
  logic cfg_ready;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [19:0] sum_w;
  logic signed [35:0] sum_wz;
`ifdef FUZZY_RULE_TRACE_EN
  logic trc_valid;
  logic [3:0] trc_idx;
  logic [15:0] trc_w;
`endif

  always #5 clk = ~clk;

  fuzzy_rule_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .muT_neg   (muT_neg),
    .muT_zero  (muT_zero),
    .muT_pos   (muT_pos),
    .muD_neg   (muD_neg),
    .muD_zero  (muD_zero),
    .muD_pos   (muD_pos),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_w     (sum_w),
    .sum_wz    (sum_wz)
`ifdef FUZZY_RULE_TRACE_EN
    ,
    .trc_valid (trc_valid),
    .trc_idx   (trc_idx),
    .trc_w     (trc_w)
`endif
  );

  typedef logic [2:0][15:0] mu3_t;
  typedef logic [8:0][15:0] ztab_t;

  typedef struct {
    string  name;
    mu3_t   mt;
    mu3_t   md;
    ztab_t  z;
    logic   hold;
    longint exp_w;
    longint exp_wz;
  } vec_t;

  int compared = 0;
  int mismatched = 0;
  longint tb_z [9];

  task automatic check(input string nm, input longint got, input longint exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: weighted sums straight from the rule grid definition
  function automatic void model(input mu3_t mt, input mu3_t md, output longint sw, output longint swz);
    sw = 0;
    swz = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        longint w;
        w = (mt[i] < md[j]) ? longint'(mt[i]) : longint'(md[j]);
        sw += w;
        swz += w * tb_z[i*3+j];
      end
    end
  endfunction

  task automatic write_cfg(input logic [3:0] a, input logic [15:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic load_table(input ztab_t z);
    for (int k = 0; k < 9; k++) begin
      write_cfg(4'(k), z[k]);
      tb_z[k] = longint'($signed(z[k]));
    end
  endtask

  task automatic set_mu(input mu3_t mt, input mu3_t md);
    muT_neg = mt[0]; muT_zero = mt[1]; muT_pos = mt[2];
    muD_neg = md[0]; muD_zero = md[1]; muD_pos = md[2];
  endtask

  // One run; wr_mode 1 writes the table on the capture edge, 2 tries a write mid-evaluation
  task automatic run(input mu3_t mt, input mu3_t md, input int wr_mode,
                     input logic [3:0] wa, input logic [15:0] wd,
                     output longint gw, output longint gwz, output int lat);
    set_mu(mt, md);
    in_valid = 1'b1;
    if (wr_mode == 1) begin
      cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
      if (wa < 9) tb_z[wa] = longint'($signed(wd));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    set_mu({16'($urandom), 16'($urandom), 16'($urandom)}, {16'($urandom), 16'($urandom), 16'($urandom)});
    lat = 0;
    while (!out_valid && lat < 40) begin
`ifdef FUZZY_RULE_TRACE_EN
      if (lat < 9) begin
        check("trc_valid", longint'(trc_valid), 1);
        check("trc_idx", longint'(trc_idx), lat);
        check("trc_w", longint'(trc_w),
              (mt[lat/3] < md[lat%3]) ? longint'(mt[lat/3]) : longint'(md[lat%3]));
      end
`endif
      if (wr_mode == 2 && lat == 3) begin
        check("cfg_ready_eval", longint'(cfg_ready), 0);
        check("in_ready_eval", longint'(in_ready), 0);
        cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
      end
      if (wr_mode == 2 && lat == 4) cfg_we = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    gw = longint'(sum_w);
    gwz = longint'(sum_wz);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) tb_z[k] = 0;
  endtask

  vec_t tbl [3];
  longint gw, gwz, ew, ewz;
  int lat;
  ztab_t zt;
  mu3_t full;

  initial begin
    full = {16'hFFFF, 16'hFFFF, 16'hFFFF};

    tbl[0].name = "rule4_only";
    tbl[0].mt = {16'h0000, 16'h8000, 16'h0000};
    tbl[0].md = {16'h0000, 16'h8000, 16'h0000};
    tbl[0].z = '0;
    tbl[0].z[4] = 16'd1000;
    tbl[0].hold = 1'b0;
    tbl[0].exp_w = 64'h8000;
    tbl[0].exp_wz = 32768000;

    tbl[1].name = "four_rules";
    tbl[1].mt = {16'h2000, 16'h4000, 16'h0000};
    tbl[1].md = {16'h0000, 16'h6000, 16'h7000};
    tbl[1].z = {9{16'd1}};
    tbl[1].hold = 1'b0;
    tbl[1].exp_w = 64'hC000;
    tbl[1].exp_wz = 64'hC000;

    tbl[2].name = "sign_path";
    tbl[2].mt = {16'h0000, 16'h0000, 16'hFFFF};
    tbl[2].md = {16'h0000, 16'h0000, 16'hFFFF};
    tbl[2].z = '0;
    tbl[2].z[0] = 16'h8000;
    tbl[2].hold = 1'b1;
    tbl[2].exp_w = 64'hFFFF;
    tbl[2].exp_wz = -64'sd2147450880;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_cfg_ready", longint'(cfg_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_sum_w", longint'(sum_w), 0);
    check("rst_sum_wz", longint'(sum_wz), 0);
    do_reset();
    check("rel_in_ready", longint'(in_ready), 1);

    // Cleared table reads back as zero weighted sum
    run({16'h1234, 16'hFFFF, 16'h0456}, {16'h8000, 16'h0001, 16'hABCD}, 0, 4'd0, 16'd0, gw, gwz, lat);
    model({16'h1234, 16'hFFFF, 16'h0456}, {16'h8000, 16'h0001, 16'hABCD}, ew, ewz);
    check("rst_table_wz", gwz, 0);
    check("rst_table_w", gw, ew);
    @(posedge clk); #1;

    // Directed vectors
    for (int v = 0; v < 3; v++) begin
      load_table(tbl[v].z);
      out_ready = !tbl[v].hold;
      run(tbl[v].mt, tbl[v].md, 0, 4'd0, 16'd0, gw, gwz, lat);
      check({tbl[v].name, "_latency"}, lat + 1, 10);
      check({tbl[v].name, "_sum_w"}, gw, tbl[v].exp_w);
      check({tbl[v].name, "_sum_wz"}, gwz, tbl[v].exp_wz);
      if (tbl[v].hold) begin
        for (int k = 0; k < 5; k++) begin
          check("hold_out_valid", longint'(out_valid), 1);
          check("hold_in_ready", longint'(in_ready), 0);
          check("hold_sum_w", longint'(sum_w), tbl[v].exp_w);
          check("hold_sum_wz", longint'(sum_wz), tbl[v].exp_wz);
          in_valid = (k == 2);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("idle_out_valid", longint'(out_valid), 0);
      check("idle_in_ready", longint'(in_ready), 1);
      check("idle_sum_w", longint'(sum_w), tbl[v].exp_w);
      check("idle_sum_wz", longint'(sum_wz), tbl[v].exp_wz);
    end

    // Out-of-range and mid-run table writes are dropped
    for (int k = 0; k < 9; k++) zt[k] = 16'(k + 1);
    load_table(zt);
    write_cfg(4'd9, 16'd999);
    write_cfg(4'd15, 16'd777);
    run(full, full, 0, 4'd0, 16'd0, gw, gwz, lat);
    model(full, full, ew, ewz);
    check("bad_addr_wz", gwz, ewz);
    @(posedge clk); #1;
    run(full, full, 2, 4'd4, 16'd5000, gw, gwz, lat);
    check("eval_write_wz", gwz, ewz);
    @(posedge clk); #1;
    run(full, full, 0, 4'd0, 16'd0, gw, gwz, lat);
    check("old_z4_wz", gwz, ewz);
    @(posedge clk); #1;
    run(full, full, 1, 4'd4, -16'sd300, gw, gwz, lat);
    model(full, full, ew, ewz);
    check("cap_write_wz", gwz, ewz);
    @(posedge clk); #1;

    // Randomized vectors against the reference
    for (int n = 0; n < 16; n++) begin
      mu3_t rt, rd;
      for (int k = 0; k < 9; k++) zt[k] = 16'($urandom);
      load_table(zt);
      for (int k = 0; k < 3; k++) begin
        rt[k] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        rd[k] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      end
      run(rt, rd, 0, 4'd0, 16'd0, gw, gwz, lat);
      model(rt, rd, ew, ewz);
      check("rand_latency", lat + 1, 10);
      check("rand_sum_w", gw, ew);
      check("rand_sum_wz", gwz, ewz);
      @(posedge clk); #1;
    end

    // Reset in the middle of evaluation
    set_mu(full, full);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_sum_w", longint'(sum_w), 0);
    check("midrst_sum_wz", longint'(sum_wz), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) tb_z[k] = 0;
    run(full, full, 0, 4'd0, 16'd0, gw, gwz, lat);
    check("midrst_table_w", gw, 9 * 64'hFFFF);
    check("midrst_table_wz", gwz, 0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
